// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment codes (bit7=a .. bit1=g, bit0=dp),
// and the capture FSM state type.
package seven_seg_pkg;

  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h19;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'hC1;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h85;
  localparam logic [7:0] SEG_E = 8'h61;

  localparam int         SEG_DP_BIT = 0;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } cap_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational inverse of the hex-to-seven-segment encoder: pattern -> {err, nibble}.
// The decimal point never affects the result; unknown patterns give nibble F with err set.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [7:0] i_pat,
  output logic       o_err,
  output logic [3:0] o_nibble
);

  logic [7:0] pat_nodp_s;

  // Force dp to its inactive level so the match only sees segments a..g
  always_comb begin
    pat_nodp_s = i_pat | (8'h01 << SEG_DP_BIT);
    o_err      = 1'b0;
    o_nibble   = 4'hF;
    case (pat_nodp_s)
      SEG_0:   o_nibble = 4'h0;
      SEG_1:   o_nibble = 4'h1;
      SEG_2:   o_nibble = 4'h2;
      SEG_3:   o_nibble = 4'h3;
      SEG_4:   o_nibble = 4'h4;
      SEG_5:   o_nibble = 4'h5;
      SEG_6:   o_nibble = 4'h6;
      SEG_7:   o_nibble = 4'h7;
      SEG_8:   o_nibble = 4'h8;
      SEG_9:   o_nibble = 4'h9;
      SEG_A:   o_nibble = 4'hA;
      SEG_B:   o_nibble = 4'hB;
      SEG_C:   o_nibble = 4'hC;
      SEG_D:   o_nibble = 4'hD;
      SEG_E:   o_nibble = 4'hE;
      default: begin
        o_nibble = 4'hF;
        o_err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Reads back a multiplexed active-low seven-segment display: synchronizes the bus, waits
// for each digit to settle, decodes it and commits a full frame once every digit was seen.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_an,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_err,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int            CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [7:0]              seg_m_q, seg_m_d, seg_s_q, seg_s_d;
  logic [NUM_DIGITS-1:0]   an_m_q, an_m_d, an_s_q, an_s_d;
  cap_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  logic                    dec_err_s;
  logic [3:0]              dec_nib_s;
  logic [NUM_DIGITS-1:0]   an_low_s;
  logic [NUM_DIGITS-1:0]   seen_next_s;
  logic                    change_s;
  logic                    single_s;
  logic                    capture_s;
  logic                    frame_done_s;

  seven_seg_decode u_decode (
    .i_pat    (seg_s_q),
    .o_err    (dec_err_s),
    .o_nibble (dec_nib_s)
  );

  // Change detection looks at the value about to enter the synchronized stage, so a change
  // on the edge the count would complete wins over the capture.
  always_comb begin
    seg_m_d      = i_seg;
    seg_s_d      = seg_m_q;
    an_m_d       = i_an;
    an_s_d       = an_m_q;
    an_low_s     = ~an_s_q;
    change_s     = (seg_m_q != seg_s_q) || (an_m_q != an_s_q);
    single_s     = (an_low_s != '0) && ((an_low_s & (an_low_s - NUM_DIGITS'(1))) == '0);
    capture_s    = (state_q == ST_SETTLE) && (cnt_q == CNT_LAST) && !change_s && single_s;
    seen_next_s  = seen_q | an_low_s;
    frame_done_s = capture_s && (&seen_next_s);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (change_s) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_HOLD;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      state_d = ST_HOLD;
    end
  end

  // Shadow slot update, frame commit and the seen bookkeeping
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_err_d = shadow_err_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (capture_s && an_low_s[k]) begin
        shadow_val_d[4*k +: 4] = dec_nib_s;
        shadow_err_d[k]        = dec_err_s;
      end else begin
        shadow_val_d[4*k +: 4] = shadow_val_q[4*k +: 4];
        shadow_err_d[k]        = shadow_err_q[k];
      end
    end

    if (frame_done_s) begin
      value_d = shadow_val_d;
      err_d   = shadow_err_d;
      seen_d  = '0;
    end else if (capture_s) begin
      value_d = value_q;
      err_d   = err_q;
      seen_d  = seen_next_s;
    end else begin
      value_d = value_q;
      err_d   = err_q;
      seen_d  = seen_q;
    end
    valid_d = frame_done_s;
    busy_d  = |seen_d;
  end

  // All state registers; synchronizers reset to the idle (all-high) bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q      <= SEG_OFF;
      seg_s_q      <= SEG_OFF;
      an_m_q       <= '1;
      an_s_q       <= '1;
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      seen_q       <= '0;
      shadow_val_q <= '0;
      shadow_err_q <= '0;
      value_q      <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      seg_m_q      <= seg_m_d;
      seg_s_q      <= seg_s_d;
      an_m_q       <= an_m_d;
      an_s_q       <= an_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      shadow_val_q <= shadow_val_d;
      shadow_err_q <= shadow_err_d;
      value_q      <= value_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign o_value = value_q;
  assign o_err   = err_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans digit patterns onto the pins and checks the
// committed frames, error flags, busy flag and number of valid pulses.
module tb_seven_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_seg;
  logic [3:0]  i_an;
  logic [15:0] o_value;
  logic [3:0]  o_err;
  logic        o_valid;
  logic        o_busy;

  int          total;
  int          bad;
  int          pulses;
  logic [15:0] last_value;
  logic [3:0]  last_err;

  seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_seg   (i_seg),
    .i_an    (i_an),
    .o_value (o_value),
    .o_err   (o_err),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every valid pulse and the frame it carried
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      pulses     = pulses + 1;
      last_value = o_value;
      last_err   = o_err;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int cycles);
    i_an  = an;
    i_seg = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int cycles);
    drive(4'b1111, 8'hFF, cycles);
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    drive(4'b1110, s0, 40);
    drive(4'b1101, s1, 40);
    drive(4'b1011, s2, 40);
    drive(4'b0111, s3, 40);
    blank(5);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_an  = 4'b1111;
    i_seg = 8'hFF;
    repeat (3) @(negedge clk);
    total++; if (o_value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h exp=0000", o_value); end
    total++; if (o_err !== 4'h0) begin bad++; $display("FAIL reset_err got=%b exp=0000", o_err); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    blank(5);
  endtask

  task automatic test_basic_scan;
    int p0;
    p0 = pulses;
    drive(4'b1110, 8'h9F, 40);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b exp=1", o_busy); end
    drive(4'b1101, 8'h25, 40);
    drive(4'b1011, 8'h0D, 40);
    drive(4'b0111, 8'h99, 40);
    blank(5);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=%0d", pulses - p0, 1); end
    total++; if (last_value !== 16'h4321) begin bad++; $display("FAIL basic_value got=%h exp=4321", last_value); end
    total++; if (last_err !== 4'h0) begin bad++; $display("FAIL basic_err got=%b exp=0000", last_err); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", o_busy); end
  endtask

  task automatic test_short_dwell;
    int   p0;
    logic busy_seen;
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h49, 8'h41, 8'h1F, 8'h01};
    p0 = pulses;
    busy_seen = 1'b0;
    for (int d = 0; d < 4; d++) begin
      i_an  = an_tab[d];
      i_seg = seg_tab[d];
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (o_busy) busy_seen = 1'b1;
      end
    end
    for (int c = 0; c < 40; c++) begin
      i_an  = 4'b1111;
      i_seg = 8'hFF;
      @(negedge clk);
      if (o_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL short_busy got=%b exp=0", busy_seen); end
    total++; if (pulses !== p0) begin bad++; $display("FAIL short_pulses got=%0d exp=0", pulses - p0); end
  endtask

  task automatic test_dp_and_illegal;
    int p0;
    p0 = pulses;
    scan(8'h49, 8'h41, 8'h02, 8'h01);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL dp_pulses got=%0d exp=1", pulses - p0); end
    total++; if (last_value !== 16'h8065) begin bad++; $display("FAIL dp_value got=%h exp=8065", last_value); end
    total++; if (last_err !== 4'b0000) begin bad++; $display("FAIL dp_err got=%b exp=0000", last_err); end
    scan(8'h49, 8'h41, 8'hFF, 8'h01);
    total++; if (pulses !== p0 + 2) begin bad++; $display("FAIL illegal_pulses got=%0d exp=2", pulses - p0); end
    total++; if (last_value !== 16'h8F65) begin bad++; $display("FAIL illegal_value got=%h exp=8F65", last_value); end
    total++; if (last_err !== 4'b0100) begin bad++; $display("FAIL illegal_err got=%b exp=0100", last_err); end
  endtask

  task automatic test_ghost;
    int p0;
    p0 = pulses;
    drive(4'b1100, 8'h1F, 40);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL ghost_busy got=%b exp=0", o_busy); end
    scan(8'h19, 8'h11, 8'hC1, 8'h61);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL ghost_pulses got=%0d exp=1", pulses - p0); end
    total++; if (last_value !== 16'hEBA9) begin bad++; $display("FAIL ghost_value got=%h exp=EBA9", last_value); end
    total++; if (last_err !== 4'b0000) begin bad++; $display("FAIL ghost_err got=%b exp=0000", last_err); end
  endtask

  task automatic test_repeat_digit;
    int p0;
    p0 = pulses;
    drive(4'b1110, 8'h49, 40);
    scan(8'h1F, 8'h03, 8'h63, 8'h85);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL repeat_pulses got=%0d exp=1", pulses - p0); end
    total++; if (last_value !== 16'hDC07) begin bad++; $display("FAIL repeat_value got=%h exp=DC07", last_value); end
    total++; if (o_value[3:0] !== 4'h7) begin bad++; $display("FAIL repeat_digit0 got=%h exp=7", o_value[3:0]); end
  endtask

  task automatic test_reset_midframe;
    int p0;
    drive(4'b1110, 8'h9F, 40);
    drive(4'b1101, 8'h25, 40);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", o_busy); end
    rst_n = 1'b0;
    i_an  = 4'b1111;
    i_seg = 8'hFF;
    repeat (2) @(negedge clk);
    total++; if (o_value !== 16'h0000) begin bad++; $display("FAIL mid_rst_value got=%h exp=0000", o_value); end
    total++; if (o_err !== 4'h0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0000", o_err); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", o_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", o_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    blank(5);
    p0 = pulses;
    drive(4'b1011, 8'h63, 40);
    drive(4'b0111, 8'h85, 40);
    blank(5);
    total++; if (pulses !== p0) begin bad++; $display("FAIL mid_partial_pulses got=%0d exp=0", pulses - p0); end
    drive(4'b1110, 8'h11, 40);
    drive(4'b1101, 8'hC1, 40);
    blank(5);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL mid_pulses got=%0d exp=1", pulses - p0); end
    total++; if (last_value !== 16'hDCBA) begin bad++; $display("FAIL mid_value got=%h exp=DCBA", last_value); end
    total++; if (o_value !== 16'hDCBA) begin bad++; $display("FAIL mid_hold_value got=%h exp=DCBA", o_value); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    pulses     = 0;
    last_value = 16'h0000;
    last_err   = 4'h0;
    rst_n      = 1'b0;
    i_an       = 4'b1111;
    i_seg      = 8'hFF;
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_dp_and_illegal();
    test_ghost();
    test_repeat_digit();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
